cache_fill_fsm: RTL and testbench
=================================

// Module: cache_fill_fsm
// PURPOSE
//   Miss-handling controller between the cache arrays and the 16-bit byte-addressed main memory.
//   On a cache miss it fetches the whole 16-byte block (8 words) from memory.
//   It issues one word read per cycle and writes each returned word into the data array.
//   After the last word it updates the tag array.
//   It stalls the pipeline (fsm_busy) for the full duration of the fill.
// PARAMETERS
//   ADDR_WIDTH   16  byte-address width; matches the memory's address port
//   WORDS_PER_BLK 8  16-bit words per cache block; power of two, >=2
//   OFFSET_BITS   4  log2(bytes per block) = log2(WORDS_PER_BLK)+1
// PORTS
//   clk               in   1   system clock; all state updates on rising edge
//   rst               in   1   asynchronous, active-high reset
//   miss_detected     in   1   cache lookup missed this cycle; sampled only in IDLE
//   miss_address      in   16  byte address of the missing access
//   memory_data_valid in   1   memory_data holds the next returned word, in issue order
//   memory_data       in   16  word returned by memory
//   fsm_busy          out  1   fill in progress; pipeline stalls while high
//   mem_enable        out  1   read request to memory this cycle (mem_wr is tied 0 by the parent)
//   memory_address    out  16  byte address of the current read request; bit 0 always 0
//   write_data_array  out  1   write fill_data into data array word fill_word_idx this cycle
//   fill_word_idx     out  3   word index within the block for the data-array write
//   fill_data         out  16  equals memory_data; passed through combinationally
//   write_tag_array   out  1   one-cycle pulse: write tag/valid for the filled block
// BEHAVIOUR
//   States: IDLE, FILL. Reset (async) -> IDLE; issue_cnt=0, recv_cnt=0, base=0; all outputs 0.
//   IDLE:
//     - fsm_busy=0, mem_enable=0, all write strobes 0.
//     - On miss_detected=1: latch base = miss_address with low OFFSET_BITS cleared.
//     - Clear both counters; next state FILL. fsm_busy rises the cycle after the miss.
//   FILL: fsm_busy=1.
//     - Issue side:
//       - mem_enable = (issue_cnt < WORDS_PER_BLK).
//       - memory_address = base | (issue_cnt[2:0] << 1).
//       - issue_cnt increments each cycle while mem_enable is high and saturates at 8.
//       - First request goes out in the first FILL cycle; 8 consecutive request cycles, no gaps.
//     - Receive side:
//       - write_data_array = memory_data_valid; fill_word_idx = recv_cnt.
//       - recv_cnt increments on each valid word.
//       - Memory latency is arbitrary >=0 cycles; responses return in order.
//     - Completion:
//       - On the valid word with recv_cnt==7, write_tag_array=1 in that same cycle.
//       - Next state IDLE; fsm_busy falls the following cycle.
//   Arithmetic:
//     - Addresses never carry out of the block. base=0xFFF0 gives 0xFFF0..0xFFFE; no wrap into 0x0000.
//     - issue_cnt is 4 bits (0..8); recv_cnt is 3 bits.
//   Boundary conditions:
//     - miss_detected while in FILL is ignored; the latched base is never updated mid-fill.
//     - memory_data_valid while in IDLE is ignored: no write strobes, no counter change.
//     - Valid word arriving in the same cycle as the last issue is accepted normally.
//     - A new miss in the first IDLE cycle after a fill is accepted; back-to-back fills are allowed.
//     - Reset asserted mid-fill: immediate return to IDLE, outputs 0, no tag write.
//       No partial-block completion is signalled.
// STRUCTURE
//   Shared package cache_pkg:
//     - State encoding (IDLE=1'b0, FILL=1'b1), WORDS_PER_BLK, OFFSET_BITS.
//     - Block-base mask function blk_base(addr).
//   Sub-module fill_counter (parameterised width, enable, sync clear, saturate flag).
//     Instantiated twice: issue count and receive count.
//   Everything else is inline FSM plus output decode; outputs are combinational from state and counters.
// TESTING
//   1. Reset: rst=1 pulsed mid-sim -> every output reads 0 immediately (before the next clk edge).
//   2. Miss at 0x1236, zero-latency memory -> addresses 0x1230,0x1232,..,0x123E on 8 consecutive cycles.
//      Expect 8 data writes idx 0..7, write_tag_array on the 8th, fsm_busy high exactly 8 cycles.
//   3. Same miss, memory_data_valid delayed 4 cycles -> mem_enable high cycles 1-8.
//      Writes in cycles 5-12, tag pulse in cycle 12, busy falls in cycle 13.
//   4. Miss at 0xFFFA -> addresses 0xFFF0..0xFFFE, no address 0x0000 issued.
//   5. miss_detected held high during fill with a different address (0x4000) -> ignored.
//      After completion, IDLE accepts it and a second fill starts from 0x4000.
//   6. rst asserted after 3 data writes -> no tag write, IDLE; next miss restarts at word 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-fill controller: geometry, state encoding
// and the block-base address helper.
package cache_pkg;

  localparam int ADDR_WIDTH    = 16;
  localparam int WORDS_PER_BLK = 8;
  localparam int OFFSET_BITS   = 4;
  localparam int RECV_W        = $clog2(WORDS_PER_BLK);
  localparam int ISSUE_W       = RECV_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  function automatic logic [ADDR_WIDTH-1:0] blk_base(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] mask;
    mask = '1;
    mask[OFFSET_BITS-1:0] = '0;
    return addr & mask;
  endfunction

endpackage

// File: rtl/fill_counter.sv
// Up-counter with enable, synchronous clear and a flag that holds the count at MAX_VAL.
module fill_counter #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             sat
);

  assign sat = (cnt == MAX_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !sat) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: fetches a whole block word by word from memory,
// streams returned words into the data array and writes the tag after the last one.
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  fsm_busy,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic [RECV_W-1:0]     fill_word_idx,
  output logic [15:0]           fill_data,
  output logic                  write_tag_array
);

  // state | meaning
  // IDLE  | waiting for a miss; counters held at zero, base latched on miss
  // FILL  | issuing reads and writing returned words until the last word lands

  fill_state_e           state, state_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic [ISSUE_W-1:0]    issue_cnt;
  logic [RECV_W-1:0]     recv_cnt;
  logic                  issue_sat, recv_last;
  logic                  in_fill;

  assign in_fill = (state == FILL);

  fill_counter #(
    .WIDTH  (ISSUE_W),
    .MAX_VAL(ISSUE_W'(WORDS_PER_BLK))
  ) u_issue_cnt (
    .clk(clk),
    .rst(rst),
    .en (mem_enable),
    .clr(!in_fill),
    .cnt(issue_cnt),
    .sat(issue_sat)
  );

  // The receive count never needs to pass the last word index: the fill ends there.
  fill_counter #(
    .WIDTH  (RECV_W),
    .MAX_VAL(RECV_W'(WORDS_PER_BLK - 1))
  ) u_recv_cnt (
    .clk(clk),
    .rst(rst),
    .en (in_fill && memory_data_valid),
    .clr(!in_fill),
    .cnt(recv_cnt),
    .sat(recv_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && miss_detected) begin
        base <= blk_base(miss_address);
      end
    end
  end

  assign fill_data = memory_data;

  always_comb begin
    state_nxt        = state;
    fsm_busy         = 1'b0;
    mem_enable       = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word_idx    = '0;
    write_tag_array  = 1'b0;
    case (state)
      IDLE: begin
        if (miss_detected) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        fsm_busy         = 1'b1;
        mem_enable       = !issue_sat;
        // OR-ing the word offset into the cleared base keeps addresses inside the block.
        memory_address   = base | ADDR_WIDTH'({issue_cnt[RECV_W-1:0], 1'b0});
        write_data_array = memory_data_valid;
        fill_word_idx    = recv_cnt;
        if (memory_data_valid && recv_last) begin
          write_tag_array = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a latency-modelling memory, a stimulus driver
// that queues expected requests/writes per fill, and a monitor that pops and compares.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_enable;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  fill_word_idx;
  logic [15:0] fill_data;
  logic        write_tag_array;

  cache_fill_fsm dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .memory_data_valid(memory_data_valid),
    .memory_data      (memory_data),
    .fsm_busy         (fsm_busy),
    .mem_enable       (mem_enable),
    .memory_address   (memory_address),
    .write_data_array (write_data_array),
    .fill_word_idx    (fill_word_idx),
    .fill_data        (fill_data),
    .write_tag_array  (write_tag_array)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          ready;
  } req_t;

  int          tests = 0;
  int          fails = 0;
  req_t        pend[$];
  logic [15:0] exp_req[$];
  logic [15:0] exp_wr[$];
  int          exp_busy[$];
  int          cyc = 0;
  int          prev_ready = 0;
  int          fixed_lat = 0;
  bit          inject = 1'b0;
  int          wr_in_fill = 0;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // Memory: accepts each request, returns its word after the chosen latency, in order.
  initial begin
    int   lat;
    req_t r;
    memory_data_valid = 1'b0;
    memory_data       = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        pend.delete();
        memory_data_valid = 1'b0;
      end else begin
        if (mem_enable) begin
          lat     = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
          r.addr  = memory_address;
          r.ready = (cyc + lat > prev_ready + 1) ? cyc + lat : prev_ready + 1;
          prev_ready = r.ready;
          pend.push_back(r);
        end
        if (pend.size() > 0 && pend[0].ready <= cyc) begin
          memory_data_valid = 1'b1;
          memory_data       = mem_fn(pend[0].addr);
          void'(pend.pop_front());
        end else begin
          memory_data_valid = inject;
          memory_data       = 16'($urandom);
        end
      end
    end
  end

  // Monitor: compares every request and every write against the queued expectations.
  initial begin
    int          busy_len;
    int          exp_len;
    logic [15:0] a;
    busy_len = 0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        busy_len   = 0;
        wr_in_fill = 0;
      end else begin
        if (mem_enable) begin
          if (exp_req.size() == 0) flag("unexpected_req", memory_address);
          else chk("req_addr", memory_address, exp_req.pop_front());
        end
        if (write_data_array || write_tag_array) begin
          if (!write_data_array) begin
            flag("tag_without_write", write_tag_array);
          end else if (exp_wr.size() == 0) begin
            flag("unexpected_write", fill_word_idx);
          end else begin
            a = exp_wr.pop_front();
            chk("wr_idx", fill_word_idx, a[3:1]);
            chk("wr_data", fill_data, mem_fn(a));
            chk("tag_pulse", write_tag_array, a[3:1] == 3'd7);
            wr_in_fill++;
          end
        end
        if (fsm_busy) begin
          busy_len++;
        end else if (busy_len > 0) begin
          if (exp_busy.size() == 0) begin
            flag("unexpected_busy", busy_len);
          end else begin
            exp_len = exp_busy.pop_front();
            if (exp_len > 0) chk("busy_len", busy_len, exp_len);
          end
          busy_len   = 0;
          wr_in_fill = 0;
        end
      end
    end
  end

  // Expected fill: 8 word requests across the block, never leaving it; 0 len = unchecked.
  task automatic push_fill(input logic [15:0] a, input int len);
    logic [15:0] b;
    b = a & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      exp_req.push_back(16'(b + 2 * i));
      exp_wr.push_back(16'(b + 2 * i));
    end
    exp_busy.push_back(len);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #4;
      n++;
    end while (fsm_busy && n < 300);
    chk(name, fsm_busy, 1'b0);
  endtask

  task automatic do_miss(input logic [15:0] a, input int lat);
    @(negedge clk);
    fixed_lat     = lat;
    miss_address  = a;
    miss_detected = 1'b1;
    push_fill(a, (lat >= 0) ? 8 + lat : 0);
    @(negedge clk);
    miss_detected = 1'b0;
    miss_address  = 16'($urandom);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, fsm_busy, 0);
    chk({tag, "_mem_en"}, mem_enable, 0);
    chk({tag, "_addr"}, memory_address, 0);
    chk({tag, "_wr_data"}, write_data_array, 0);
    chk({tag, "_idx"}, fill_word_idx, 0);
    chk({tag, "_tag"}, write_tag_array, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    logic [15:0] a;
    rst           = 1'b1;
    miss_detected = 1'b0;
    miss_address  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Zero latency, then 4-cycle latency, then top-of-memory block.
    do_miss(16'h1236, 0);
    wait_idle("fill0_done");
    do_miss(16'h1236, 4);
    wait_idle("fill_lat4_done");
    do_miss(16'hFFFA, 0);
    wait_idle("fill_top_done");

    // Miss held high mid-fill with another address; taken right after the fill ends.
    @(negedge clk);
    fixed_lat     = 0;
    miss_address  = 16'h1236;
    miss_detected = 1'b1;
    push_fill(16'h1236, 8);
    @(negedge clk);
    miss_address = 16'h4000;
    n = 0;
    do begin
      @(negedge clk);
      #4;
      n++;
    end while (fsm_busy && n < 100);
    chk("held_miss_first_done", fsm_busy, 1'b0);
    push_fill(16'h4000, 8);
    @(negedge clk);
    miss_detected = 1'b0;
    wait_idle("held_miss_second_done");

    // Stray valid words while idle must not write anything.
    @(negedge clk);
    inject = 1'b1;
    repeat (4) @(negedge clk);
    inject = 1'b0;

    // Reset after three data writes, then a fresh fill from word 0.
    do_miss(16'h2468, 1);
    n = 0;
    while (wr_in_fill < 3 && n < 100) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk("writes_before_reset", wr_in_fill, 3);
    @(negedge clk);
    rst = 1'b1;
    exp_req.delete();
    exp_wr.delete();
    exp_busy.delete();
    #1;
    chk_outputs_zero("midfill_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_miss(16'h2468, 0);
    wait_idle("after_reset_done");

    // Randomized fills with fixed or per-word random latency.
    for (int k = 0; k < 10; k++) begin
      a   = 16'($urandom);
      lat = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 6));
      do_miss(a, lat);
      wait_idle("rand_fill_done");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("req_queue_drained", exp_req.size(), 0);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("busy_queue_drained", exp_busy.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
